// File: rtl/sig_field_gen.sv
// SIGNAL field serializer: builds the 24-bit RATE/LENGTH/parity/tail field and shifts it out LSB-first.
// Optional macro SIG_PAD32_EN pads the burst to 32 bits with trailing zeros.
module sig_field_gen #(
  parameter logic [5:0] ENC_INIT = 6'b000000
) (
  input  logic        sce_clk_i,
  input  logic        sce_rst,
  input  logic        start,
  input  logic [3:0]  rate,
  input  logic [11:0] length,
  output logic        sce_do,
  output logic        sce_do_vld,
  output logic [5:0]  sce_do_init,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef SIG_PAD32_EN
  localparam int unsigned NBITS = 32;
`else
  localparam int unsigned NBITS = 24;
`endif
  localparam logic [4:0] LAST = 5'(NBITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [NBITS-1:0] build_field(input logic [3:0] r, input logic [11:0] l);
    logic [NBITS-1:0] f;
    f       = '0;
    f[0]    = r[3];
    f[1]    = r[2];
    f[2]    = r[1];
    f[3]    = r[0];
    f[16:5] = l;
    f[17]   = ^f[16:0];
    return f;
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       rate_q, rate_d;
  logic [11:0]      len_q, len_d;
  logic             do_q, do_d;
  logic             vld_q, vld_d;
  logic [5:0]       init_q, init_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [NBITS-1:0] field_cur;
  logic [NBITS-1:0] field_new;
  logic             legal;
  logic             at_last;
  logic             sample;

  always_comb begin
    field_cur = build_field(rate_q, len_q);
    field_new = build_field(rate, length);
    legal     = rate[3] & (length != 12'd0);
    at_last   = (state_q == SHIFT) && (cnt_q == LAST);
    // The last-bit edge doubles as an IDLE sampling edge so bursts can chain.
    sample    = (state_q == IDLE) || at_last;

    state_d = state_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    len_d   = len_q;
    do_d    = 1'b0;
    vld_d   = 1'b0;
    init_d  = 6'd0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (sample && start && legal) begin
      state_d = SHIFT;
      cnt_d   = 5'd0;
      rate_d  = rate;
      len_d   = length;
      do_d    = field_new[0];
      vld_d   = 1'b1;
      init_d  = ENC_INIT;
    end else if ((state_q == SHIFT) && !at_last) begin
      cnt_d  = cnt_q + 5'd1;
      do_d   = field_cur[cnt_d];
      vld_d  = 1'b1;
      init_d = ENC_INIT;
      done_d = (cnt_d == LAST);
    end else begin
      state_d = IDLE;
      err_d   = sample && start && !legal;
    end
  end

  always_ff @(posedge sce_clk_i or posedge sce_rst) begin
    if (sce_rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rate_q  <= 4'd0;
      len_q   <= 12'd0;
      do_q    <= 1'b0;
      vld_q   <= 1'b0;
      init_q  <= 6'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      len_q   <= len_d;
      do_q    <= do_d;
      vld_q   <= vld_d;
      init_q  <= init_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sce_do      = do_q;
  assign sce_do_vld  = vld_q;
  assign sce_do_init = init_q;
  assign busy        = (state_q == SHIFT);
  assign done        = done_q;
  assign err         = err_q;

endmodule
